// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM state encoding,
// binary-to-Gray mapping and a saturating increment.
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MAX_N  = 16;
   localparam int MAX_CW = 32;

   // Callers zero-extend narrower vectors; upper zero bits leave the low N bits exact.
   function automatic logic [MAX_N-1:0] bin2gray(input logic [MAX_N-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [MAX_CW-1:0] sat_inc(input logic [MAX_CW-1:0] v,
                                                 input logic [MAX_CW-1:0] max_v);
      return (v == max_v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/check bus between the sweeper and its controller/DUT harness.
// slave = sweeper side, master = the harness that starts sweeps and feeds DUT results.
interface truth_table_sweeper_if #(
   parameter int N  = 3,
   parameter int M  = 1,
   parameter int CW = 16
);
   logic          start;
   logic [N-1:0]  stim;
   logic [M-1:0]  dut_y;
   logic [M-1:0]  exp_y;
   logic          busy;
   logic          done;
   logic          err;
   logic [CW-1:0] err_count;
   logic [N-1:0]  first_err_vec;

   modport master (
      output start, dut_y, exp_y,
      input  stim, busy, done, err, err_count, first_err_vec
   );

   modport slave (
      input  start, dut_y, exp_y,
      output stim, busy, done, err, err_count, first_err_vec
   );
endinterface

// File: rtl/truth_table_sweeper_counter.sv
// Two-level vector/hold counter: hc walks 0..HOLD-1 inside each idx 0..2^N-1,
// wrapping to zero after the final hold of the final vector.
module sweep_counter #(
   parameter int N    = 3,
   parameter int HOLD = 10,
   localparam int HW  = (HOLD > 1) ? $clog2(HOLD) : 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [N-1:0] idx,
   output logic         last_vec,
   output logic         last_hold
);

   // One spare bit so the terminal compare never aliases through overflow.
   localparam logic [N:0]    LAST_IDX = {1'b0, {N{1'b1}}};
   localparam logic [HW-1:0] LAST_HC  = HW'(HOLD - 1);

   logic [N:0]    idx_q;
   logic [HW-1:0] hc_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         idx_q <= '0;
         hc_q  <= '0;
      end else if (en) begin
         if (last_hold) begin
            hc_q  <= '0;
            idx_q <= last_vec ? '0 : idx_q + 1'b1;
         end else begin
            hc_q <= hc_q + 1'b1;
         end
      end
   end

   assign last_hold = (hc_q == LAST_HC);
   assign last_vec  = (idx_q == LAST_IDX);
   assign idx       = idx_q[N-1:0];

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every N-bit input vector of a combinational DUT, holding each for HOLD
// cycles and comparing dut_y against exp_y on the last cycle of each hold.
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int N    = 3,
   parameter int M    = 1,
   parameter int HOLD = 10,
   parameter int GRAY = 0,
   parameter int CW   = 16
) (
   input logic                clk,
   input logic                reset,
   truth_table_sweeper_if.slave bus
);

   localparam logic [CW-1:0] ERR_MAX = {CW{1'b1}};

   state_t        state_q, state_d;
   logic          cnt_clr, cmp_fire, start_ok, mismatch;
   logic [N-1:0]  idx, vec_map;
   logic          last_vec, last_hold;
   logic          err_q;
   logic [CW-1:0] err_count_q;
   logic [N-1:0]  first_q;

   sweep_counter #(.N(N), .HOLD(HOLD)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .en       (1'b1),
      .idx      (idx),
      .last_vec (last_vec),
      .last_hold(last_hold)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Counters are held at zero outside RUN so every sweep begins at vector 0.
   always_comb begin
      state_d  = state_q;
      cnt_clr  = 1'b1;
      cmp_fire = 1'b0;
      start_ok = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d  = RUN;
               start_ok = 1'b1;
            end
         end
         RUN: begin
            cnt_clr  = 1'b0;
            cmp_fire = last_hold;
            if (last_hold && last_vec) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mismatch = (bus.dut_y != bus.exp_y);

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q       <= 1'b0;
         err_count_q <= '0;
         first_q     <= '0;
      end else begin
         err_q <= cmp_fire && mismatch;
         if (start_ok) begin
            err_count_q <= '0;
            first_q     <= '0;
         end else if (cmp_fire && mismatch) begin
            err_count_q <= CW'(sat_inc(MAX_CW'(err_count_q), MAX_CW'(ERR_MAX)));
            if (err_count_q == '0) first_q <= idx;
         end
      end
   end

   generate
      if (GRAY != 0) begin : g_gray
         assign vec_map = N'(bin2gray(MAX_N'(idx)));
      end else begin : g_bin
         assign vec_map = idx;
      end
   endgenerate

   assign bus.stim          = (state_q == RUN) ? vec_map : '0;
   assign bus.busy          = (state_q == RUN);
   assign bus.done          = (state_q == DONE);
   assign bus.err           = err_q;
   assign bus.err_count     = err_count_q;
   assign bus.first_err_vec = first_q;

endmodule
